pux_ex: RTL and testbench

- Word-serial big-integer execution stage directly downstream of the PUX stream interface.
- Takes one opcode per operation from the interface's opcode stream, then consumes A and B operand words (LSW first) in lock-step.
- Streams out result words and ends every operation with exactly one status beat.
- Supported operations: add-with-carry, subtract-with-borrow, compare, no-op.

---
 rtl/pux_pkg.sv | 31 +++
 rtl/pux_ex_addsub.sv | 37 +++
 rtl/pux_ex.sv | 202 ++++++++++++++++++++
 tb/tb_pux_ex.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pux_pkg.sv
// -----------------------------------------------------------------------------
// pux_pkg
//   Shared definitions for the PUX execution stages: opcode field positions,
//   operation encodings, status bit indices and the execution FSM states.
// -----------------------------------------------------------------------------
package pux_pkg;

    // Operation field position inside the opcode word.
    localparam int PUX_OP_MSB = 7;
    localparam int PUX_OP_LSB = 6;

    // Operation encodings.
    typedef enum logic [1:0] {
        PUX_OP_ADD = 2'b00,
        PUX_OP_SUB = 2'b01,
        PUX_OP_CMP = 2'b10,
        PUX_OP_NOP = 2'b11
    } pux_op_e;

    // Status beat bit indices: status = {zero, carry}.
    localparam int PUX_ST_CARRY = 0;
    localparam int PUX_ST_ZERO  = 1;

    // Execution FSM states.
    typedef enum logic [1:0] {
        PUX_ST_IDLE = 2'b00,
        PUX_ST_RUN  = 2'b01,
        PUX_ST_STAT = 2'b10
    } pux_state_e;

endpackage : pux_pkg

// File: rtl/pux_ex_addsub.sv
// -----------------------------------------------------------------------------
// pux_ex_addsub
//   Combinational DATAW-bit adder/subtractor with carry/borrow in and out.
//   Shared by the execution stage and the modular-reduction stage.
//
// Ports:
//   i_a, i_b  operand words
//   i_sub     0: r = a + b + cin       1: r = a - b - cin
//   i_cin     carry in (add) / borrow in (sub)
//   o_r       result word
//   o_cout    carry out (add) / borrow out (sub)
// -----------------------------------------------------------------------------
module pux_ex_addsub #(
    parameter int DATAW = 16
) (
    input  logic [DATAW-1:0] i_a,
    input  logic [DATAW-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_cin,
    output logic [DATAW-1:0] o_r,
    output logic             o_cout
);

    logic [DATAW:0] w_sum;
    logic [DATAW:0] w_diff;
    logic [DATAW:0] w_cin_ext;

    assign w_cin_ext = {{DATAW{1'b0}}, i_cin};
    assign w_sum     = {1'b0, i_a} + {1'b0, i_b} + w_cin_ext;
    // a - b - cin lies in [-2^DATAW, 2^DATAW-1], so at DATAW+1 bits the
    // sign bit is exactly the borrow (a < b + cin).
    assign w_diff    = {1'b0, i_a} - {1'b0, i_b} - w_cin_ext;

    assign o_r    = i_sub ? w_diff[DATAW-1:0] : w_sum[DATAW-1:0];
    assign o_cout = i_sub ? w_diff[DATAW]     : w_sum[DATAW];

endmodule : pux_ex_addsub

// File: rtl/pux_ex.sv
// -----------------------------------------------------------------------------
// pux_ex
//   Word-serial big-integer execution stage. Accepts one opcode, then consumes
//   A/B operand words (LSW first) in lock-step, streams result words and ends
//   every operation with one {zero, carry} status beat.
//   Operations: ADD, SUB (with borrow), CMP (SUB without result beats), NOP.
//
// Ports:
//   axis_clk / axis_rst              clock, synchronous active-high reset
//   axis_opcode_*                    opcode stream ([7:6] op, [LENW-1:0] nwords-1)
//   axis_abuff_* / axis_bbuff_*      operand word streams (popped together)
//   axis_res_*                       result word stream (ADD/SUB only)
//   axis_status_*                    status beat {zero, carry}
//   axis_res_last                    final result word marker (PUX_EX_TLAST_EN)
//
// Build option:
//   PUX_EX_TLAST_EN  adds axis_res_last.
// -----------------------------------------------------------------------------
module pux_ex
    import pux_pkg::*;
#(
    parameter int OPCW    = 8,
    parameter int DATAW   = 16,
    parameter int STATUSW = 2,
    parameter int LENW    = 4
) (
    input  logic               axis_clk,
    input  logic               axis_rst,
    input  logic [OPCW-1:0]    axis_opcode_data,
    input  logic               axis_opcode_valid,
    output logic               axis_opcode_ready,
    input  logic [DATAW-1:0]   axis_abuff_data,
    input  logic               axis_abuff_valid,
    output logic               axis_abuff_ready,
    input  logic [DATAW-1:0]   axis_bbuff_data,
    input  logic               axis_bbuff_valid,
    output logic               axis_bbuff_ready,
    output logic [DATAW-1:0]   axis_res_data,
    output logic               axis_res_valid,
    input  logic               axis_res_ready,
`ifdef PUX_EX_TLAST_EN
    output logic               axis_res_last,
`endif
    output logic [STATUSW-1:0] axis_status_data,
    output logic               axis_status_valid,
    input  logic               axis_status_ready
);

    pux_state_e       r_state;
    pux_state_e       w_state_nxt;
    pux_op_e          r_op;
    pux_op_e          w_opc_op;
    logic [LENW-1:0]  r_nwords_m1;
    logic [LENW-1:0]  r_count;
    logic             r_carry;
    logic             r_zacc;
    logic [DATAW-1:0] r_res_data;
    logic             r_res_valid;

    logic             w_opc_hs;
    logic             w_res_free;
    logic             w_step;
    logic             w_last;
    logic             w_stat_valid;
    logic             w_stat_hs;
    logic [DATAW-1:0] w_r;
    logic             w_cout;
    logic             w_unused_opc;

    // Reserved opcode bits carry no meaning here.
    assign w_unused_opc = ^axis_opcode_data[PUX_OP_LSB-1:LENW];

    assign w_opc_op   = pux_op_e'(axis_opcode_data[PUX_OP_MSB:PUX_OP_LSB]);
    assign w_opc_hs   = (r_state == PUX_ST_IDLE) && !axis_rst && axis_opcode_valid;

    // The result register can accept a word when empty or emptied this cycle.
    assign w_res_free = !r_res_valid || axis_res_ready;

    // CMP produces no result beats, so it never waits on the result register.
    assign w_step = (r_state == PUX_ST_RUN) && !axis_rst
                    && axis_abuff_valid && axis_bbuff_valid
                    && ((r_op == PUX_OP_CMP) || w_res_free);
    assign w_last = (r_count == r_nwords_m1);

    // Status waits until the last result word has left the register.
    assign w_stat_valid = (r_state == PUX_ST_STAT) && !axis_rst && w_res_free;
    assign w_stat_hs    = w_stat_valid && axis_status_ready;

    pux_ex_addsub #(
        .DATAW (DATAW)
    ) u_addsub (
        .i_a    (axis_abuff_data),
        .i_b    (axis_bbuff_data),
        .i_sub  (r_op != PUX_OP_ADD),
        .i_cin  (r_carry),
        .o_r    (w_r),
        .o_cout (w_cout)
    );

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt       = r_state;
        axis_opcode_ready = 1'b0;
        axis_abuff_ready  = 1'b0;
        axis_bbuff_ready  = 1'b0;
        axis_status_valid = 1'b0;
        axis_status_data  = '0;

        axis_status_data[PUX_ST_ZERO]  = r_zacc;
        axis_status_data[PUX_ST_CARRY] = r_carry;

        case (r_state)
            PUX_ST_IDLE: begin
                axis_opcode_ready = !axis_rst;
                if (w_opc_hs) begin
                    w_state_nxt = (w_opc_op == PUX_OP_NOP) ? PUX_ST_STAT : PUX_ST_RUN;
                end
            end
            PUX_ST_RUN: begin
                // Both operand streams are popped together, never singly.
                axis_abuff_ready = w_step;
                axis_bbuff_ready = w_step;
                if (w_step && w_last) begin
                    w_state_nxt = PUX_ST_STAT;
                end
            end
            PUX_ST_STAT: begin
                axis_status_valid = w_stat_valid;
                if (w_stat_hs) begin
                    w_state_nxt = PUX_ST_IDLE;
                end
            end
            default: w_state_nxt = PUX_ST_IDLE;
        endcase
    end

    // Control state and accumulators.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_state     <= PUX_ST_IDLE;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_zacc      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_opc_hs) begin
                r_count <= '0;
                r_carry <= 1'b0;
                r_zacc  <= 1'b1;
            end

            if (w_step) begin
                r_carry <= w_cout;
                r_zacc  <= r_zacc && (w_r == '0);
                // Cleared on the last word so nwords = 2^LENW never wraps
                // into a further step.
                r_count <= w_last ? '0 : r_count + 1'b1;
            end

            if (w_step && (r_op != PUX_OP_CMP)) begin
                r_res_valid <= 1'b1;
            end else if (axis_res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // NOTE: pure datapath registers are not reset; they are always written
    // before being observed (op/length at the opcode handshake, result word
    // together with its valid).
    always_ff @(posedge axis_clk) begin
        if (w_opc_hs) begin
            r_op        <= w_opc_op;
            r_nwords_m1 <= axis_opcode_data[LENW-1:0];
        end
        if (w_step && (r_op != PUX_OP_CMP)) begin
            r_res_data <= w_r;
        end
    end

    assign axis_res_data  = r_res_data;
    assign axis_res_valid = r_res_valid;

`ifdef PUX_EX_TLAST_EN
    logic r_res_last;

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_res_last <= 1'b0;
        end else if (w_step && (r_op != PUX_OP_CMP)) begin
            r_res_last <= w_last;
        end
    end

    assign axis_res_last = r_res_last;
`endif

endmodule : pux_ex

// File: tb/tb_pux_ex.sv
// -----------------------------------------------------------------------------
// tb_pux_ex
//   Self-checking bench for pux_ex: directed vector table, randomized
//   operations against a big-integer reference model, and hand-written
//   back-pressure / reset-abort / maximum-length sequences.
// -----------------------------------------------------------------------------
module tb_pux_ex;

    logic        axis_clk;
    logic        axis_rst;
    logic [7:0]  axis_opcode_data;
    logic        axis_opcode_valid;
    logic        axis_opcode_ready;
    logic [15:0] axis_abuff_data;
    logic        axis_abuff_valid;
    logic        axis_abuff_ready;
    logic [15:0] axis_bbuff_data;
    logic        axis_bbuff_valid;
    logic        axis_bbuff_ready;
    logic [15:0] axis_res_data;
    logic        axis_res_valid;
    logic        axis_res_ready;
    logic [1:0]  axis_status_data;
    logic        axis_status_valid;
    logic        axis_status_ready;

    pux_ex dut (
        .axis_clk          (axis_clk),
        .axis_rst          (axis_rst),
        .axis_opcode_data  (axis_opcode_data),
        .axis_opcode_valid (axis_opcode_valid),
        .axis_opcode_ready (axis_opcode_ready),
        .axis_abuff_data   (axis_abuff_data),
        .axis_abuff_valid  (axis_abuff_valid),
        .axis_abuff_ready  (axis_abuff_ready),
        .axis_bbuff_data   (axis_bbuff_data),
        .axis_bbuff_valid  (axis_bbuff_valid),
        .axis_bbuff_ready  (axis_bbuff_ready),
        .axis_res_data     (axis_res_data),
        .axis_res_valid    (axis_res_valid),
        .axis_res_ready    (axis_res_ready),
        .axis_status_data  (axis_status_data),
        .axis_status_valid (axis_status_valid),
        .axis_status_ready (axis_status_ready)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Operands of the current operation and what the DUT returned.
    logic [15:0] in_a [16];
    logic [15:0] in_b [16];
    logic [15:0] got_res [$];
    logic [1:0]  got_st;
    bit          op_done;
    int          viol;

    // Expected results.
    logic [15:0] exp_res [$];
    logic [1:0]  exp_st;

    typedef struct {
        logic [7:0]  opc;
        int          n;
        logic [15:0] a0, a1, b0, b1;
        int          nres;
        logic [15:0] r0, r1;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs [8];
    int   nv = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] opc, input int n,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] b0, input logic [15:0] b1,
                           input int nres, input logic [15:0] r0, input logic [15:0] r1,
                           input logic [1:0] st);
        vecs[nv].opc = opc; vecs[nv].n = n;
        vecs[nv].a0 = a0; vecs[nv].a1 = a1; vecs[nv].b0 = b0; vecs[nv].b1 = b1;
        vecs[nv].nres = nres; vecs[nv].r0 = r0; vecs[nv].r1 = r1; vecs[nv].st = st;
        nv++;
    endtask

    // Reference model: operands as whole big integers.
    task automatic model(input logic [7:0] opc, input int n);
        logic [271:0] va, vb, vs;
        logic         carry;
        logic         zero;
        logic [1:0]   op;
        op = opc[7:6];
        va = '0;
        vb = '0;
        for (int i = 0; i < n; i++) begin
            va[16*i +: 16] = in_a[i];
            vb[16*i +: 16] = in_b[i];
        end
        exp_res.delete();
        if (op == 2'b11) begin
            exp_st = 2'b10;
        end else begin
            if (op == 2'b00) begin
                vs    = va + vb;
                carry = vs[16*n];
            end else begin
                vs    = va - vb;
                carry = (va < vb);
            end
            zero = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (vs[16*i +: 16] != 16'h0) zero = 1'b0;
                if (op != 2'b10) exp_res.push_back(vs[16*i +: 16]);
            end
            exp_st = {zero, carry};
        end
    endtask

    // Runs one operation. mode 0: sinks always ready; 1: random sinks;
    // 2: result sink held low for 5 cycles once the first result appears.
    task automatic do_op(input logic [7:0] opc, input int n, input int mode, input bit rand_valid);
        int          ai;
        int          cyc;
        int          hold;
        bit          opc_sent;
        bit          seen_first;
        bit          held_v;
        logic [15:0] held;
        got_res.delete();
        viol = 0; ai = 0; cyc = 0; hold = 0;
        opc_sent = 0; seen_first = 0; held_v = 0; held = '0;
        op_done = 0;
        while (!op_done && cyc < 2000) begin
            @(negedge axis_clk);
            axis_opcode_valid = !opc_sent;
            axis_opcode_data  = opc;
            axis_abuff_valid  = opc_sent && (ai < n) && (!rand_valid || $urandom_range(0, 3) != 0);
            axis_bbuff_valid  = opc_sent && (ai < n) && (!rand_valid || $urandom_range(0, 3) != 0);
            axis_abuff_data   = (ai < 16) ? in_a[ai] : 16'(($urandom));
            axis_bbuff_data   = (ai < 16) ? in_b[ai] : 16'(($urandom));
            if (axis_res_valid) seen_first = 1;
            case (mode)
                1:       axis_res_ready = ($urandom_range(0, 2) != 0);
                2:       axis_res_ready = !(seen_first && hold < 5);
                default: axis_res_ready = 1'b1;
            endcase
            if (mode == 2 && !axis_res_ready) hold++;
            axis_status_ready = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (axis_abuff_ready != axis_bbuff_ready) viol++;
            if (axis_abuff_ready && !(axis_abuff_valid && axis_bbuff_valid)) viol++;
            if (axis_abuff_ready && axis_res_valid && !axis_res_ready && opc[7:6] != 2'b10) viol++;
            if (axis_status_valid && axis_res_valid && !axis_res_ready) viol++;
            if (held_v && (!axis_res_valid || axis_res_data != held)) viol++;
            held_v = axis_res_valid && !axis_res_ready;
            held   = axis_res_data;
            if (axis_opcode_valid && axis_opcode_ready) opc_sent = 1;
            if (axis_abuff_valid && axis_abuff_ready) ai++;
            if (axis_res_valid && axis_res_ready) got_res.push_back(axis_res_data);
            if (axis_status_valid && axis_status_ready) begin
                op_done = 1;
                got_st  = axis_status_data;
            end
            cyc++;
        end
        @(negedge axis_clk);
        axis_opcode_valid = 1'b0;
        axis_abuff_valid  = 1'b0;
        axis_bbuff_valid  = 1'b0;
        axis_status_ready = 1'b0;
    endtask

    task automatic compare_op(input string tag);
        int m;
        check({tag, " status beat seen"}, 32'(op_done), 32'd1);
        check({tag, " protocol violations"}, viol, 0);
        check({tag, " result count"}, got_res.size(), exp_res.size());
        m = (got_res.size() < exp_res.size()) ? got_res.size() : exp_res.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s res[%0d]", tag, i), 32'(got_res[i]), 32'(exp_res[i]));
        end
        check({tag, " status"}, 32'(got_st), 32'(exp_st));
    endtask

    initial begin
        logic [1:0] op;
        int         n;
        int         k;

        axis_rst          = 1'b1;
        axis_opcode_data  = '0;
        axis_opcode_valid = 1'b0;
        axis_abuff_data   = '0;
        axis_abuff_valid  = 1'b0;
        axis_bbuff_data   = '0;
        axis_bbuff_valid  = 1'b0;
        axis_res_ready    = 1'b0;
        axis_status_ready = 1'b0;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        axis_rst = 1'b0;
        #1;
        check("reset res_valid",    32'(axis_res_valid),    32'd0);
        check("reset status_valid", 32'(axis_status_valid), 32'd0);
        check("reset abuff_ready",  32'(axis_abuff_ready),  32'd0);
        check("reset bbuff_ready",  32'(axis_bbuff_ready),  32'd0);
        check("reset opcode_ready", 32'(axis_opcode_ready), 32'd1);

        // Directed vectors.
        add_vec(8'h01, 2, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 2, 16'h0000, 16'h0002, 2'b00);
        add_vec(8'h00, 1, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 1, 16'h0000, 16'h0000, 2'b11);
        add_vec(8'h40, 1, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 1, 16'hFFFF, 16'h0000, 2'b01);
        add_vec(8'h81, 2, 16'h1234, 16'h5678, 16'h1234, 16'h5678, 0, 16'h0000, 16'h0000, 2'b10);
        add_vec(8'h81, 2, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 0, 16'h0000, 16'h0000, 2'b01);
        add_vec(8'hC0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 2'b10);
        for (int i = 0; i < nv; i++) begin
            in_a[0] = vecs[i].a0; in_a[1] = vecs[i].a1;
            in_b[0] = vecs[i].b0; in_b[1] = vecs[i].b1;
            exp_res.delete();
            if (vecs[i].nres > 0) exp_res.push_back(vecs[i].r0);
            if (vecs[i].nres > 1) exp_res.push_back(vecs[i].r1);
            exp_st = vecs[i].st;
            do_op(vecs[i].opc, vecs[i].n, 0, 0);
            compare_op($sformatf("vec%0d", i));
        end

        // ADD over 4 words with the result sink stalled after the first beat.
        for (int i = 0; i < 4; i++) begin
            in_a[i] = 16'(($urandom));
            in_b[i] = 16'(($urandom));
        end
        model(8'h03, 4);
        do_op(8'h03, 4, 2, 0);
        compare_op("backpressure");

        // Maximum length: carry ripples through all 16 words.
        for (int i = 0; i < 16; i++) begin
            in_a[i] = 16'hFFFF;
            in_b[i] = (i == 0) ? 16'h0001 : 16'h0000;
        end
        model(8'h0F, 16);
        do_op(8'h0F, 16, 0, 1);
        compare_op("max_len");
        check("max_len status literal", 32'(got_st), 32'h3);

        // Reset after the first of 4 ADD words.
        for (int i = 0; i < 4; i++) begin
            in_a[i] = 16'h1000 + 16'(i);
            in_b[i] = 16'h0100;
        end
        @(negedge axis_clk);
        axis_opcode_data  = 8'h03;
        axis_opcode_valid = 1'b1;
        #1;
        check("abort opcode accepted", 32'(axis_opcode_ready), 32'd1);
        @(negedge axis_clk);
        axis_opcode_valid = 1'b0;
        axis_abuff_data   = in_a[0];
        axis_bbuff_data   = in_b[0];
        axis_abuff_valid  = 1'b1;
        axis_bbuff_valid  = 1'b1;
        axis_res_ready    = 1'b1;
        #1;
        check("abort first step", 32'(axis_abuff_ready && axis_bbuff_ready), 32'd1);
        @(negedge axis_clk);
        axis_rst = 1'b1;
        @(negedge axis_clk);
        axis_rst = 1'b0;
        #1;
        check("abort res_valid",    32'(axis_res_valid),    32'd0);
        check("abort status_valid", 32'(axis_status_valid), 32'd0);
        check("abort abuff_ready",  32'(axis_abuff_ready),  32'd0);
        check("abort bbuff_ready",  32'(axis_bbuff_ready),  32'd0);
        check("abort opcode_ready", 32'(axis_opcode_ready), 32'd1);
        axis_abuff_valid = 1'b0;
        axis_bbuff_valid = 1'b0;
        model(8'hC0, 0);
        do_op(8'hC0, 0, 0, 0);
        compare_op("nop_after_abort");

        // Randomized operations against the reference model.
        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            n  = $urandom_range(1, 16);
            k  = $urandom_range(0, 3);
            for (int i = 0; i < 16; i++) begin
                in_a[i] = (k == 0) ? 16'hFFFF : 16'(($urandom));
                in_b[i] = (k == 1) ? in_a[i] : ((k == 0 && i > 0) ? 16'h0000 : 16'(($urandom)));
            end
            model({op, 2'($urandom_range(0, 3)), 4'(n - 1)}, n);
            do_op({op, 2'($urandom_range(0, 3)), 4'(n - 1)}, (op == 2'b11) ? 0 : n,
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            compare_op($sformatf("rand%0d op%0d n%0d", t, op, n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pux_ex
